mem_access_unit: RTL and testbench

Memory-stage load/store unit sitting directly downstream of the EX/MEM pipeline register. It turns the registered ALU result (address), store data and memory control bits into a request/ready transaction on the data-memory port. It formats load data (byte/half/word, signed/unsigned) for the MEM/WB register and holds the upstream pipeline with a stall while a transaction is outstanding.

---
 rtl/mem_access_unit.sv | 129 ++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: issues one request/ready transaction per access,
// formats load data for MEM/WB and stalls the upstream pipeline while busy.
module mem_access_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic [2:0]        funct3_in,
   input  logic [31:0]       addr_in,
   input  logic [31:0]       store_data_in,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic              dmem_ready,
   input  logic [31:0]       dmem_rdata,
   output logic [31:0]       load_data_out,
   output logic              stall_out,
   output logic              misaligned_out
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_n;
   logic              access;
   logic              req_p0, we_p0;
   logic [ADDR_W-1:0] addr_p0;
   logic [31:0]       wdata_p0, load_p0;
   logic [3:0]        wstrb_p0;

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
      case (size)
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   function automatic logic [3:0] store_strobes(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   return 4'b0001 << lane;
         2'b01:   return 4'b0011 << lane;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] w);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] r;
      b = w[{lane, 3'b000} +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  r = 32'(b);
         3'b001:  r = 32'(h);
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = w;
      endcase
      return r;
   endfunction

   always_comb begin
      misaligned_out = 1'b0;
      if (mem_read_in || mem_write_in) begin
         if (funct3_in[1:0] == 2'b01)      misaligned_out = addr_in[0];
         else if (funct3_in[1:0] == 2'b10) misaligned_out = (addr_in[1:0] != 2'b00);
      end
   end

   assign access    = (mem_read_in || mem_write_in) && !misaligned_out;
   assign stall_out = ((state == IDLE) && access) || (state == BUSY);

   always_comb begin
      state_n  = state;
      req_p0   = dmem_req;
      we_p0    = dmem_we;
      addr_p0  = dmem_addr;
      wdata_p0 = dmem_wdata;
      wstrb_p0 = dmem_wstrb;
      load_p0  = load_data_out;
      case (state)
         IDLE: if (access) begin
            state_n  = BUSY;
            req_p0   = 1'b1;
            we_p0    = mem_write_in;
            addr_p0  = {addr_in[ADDR_W-1:2], 2'b00};
            wdata_p0 = store_lanes(funct3_in[1:0], store_data_in);
            wstrb_p0 = mem_write_in ? store_strobes(funct3_in[1:0], addr_in[1:0]) : 4'b0000;
         end
         // The EX/MEM slot is frozen by stall_out, so funct3/addr are still this access.
         BUSY: if (dmem_ready) begin
            state_n  = DONE;
            req_p0   = 1'b0;
            we_p0    = 1'b0;
            wstrb_p0 = 4'b0000;
            if (!dmem_we) load_p0 = load_format(funct3_in, addr_in[1:0], dmem_rdata);
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Stage boundary: memory port and MEM/WB load result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_wstrb    <= '0;
         load_data_out <= '0;
      end else begin
         state         <= state_n;
         dmem_req      <= req_p0;
         dmem_we       <= we_p0;
         dmem_addr     <= addr_p0;
         dmem_wdata    <= wdata_p0;
         dmem_wstrb    <= wstrb_p0;
         load_data_out <= load_p0;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests and load results are
// queued when an access is driven and compared when the DUT produces them.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_read_in, mem_write_in;
   logic [2:0]  funct3_in;
   logic [31:0] addr_in, store_data_in;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic [31:0] load_data_out;
   logic        stall_out, misaligned_out;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   req_t        req_q[$];
   logic [31:0] ld_q[$];
   logic [31:0] last_ld;
   int          n_checks = 0;
   int          n_fail   = 0;

   mem_access_unit #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
      .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .load_data_out(load_data_out), .stall_out(stall_out),
      .misaligned_out(misaligned_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] lane,
                                            input logic [31:0] w);
      logic [31:0]        s;
      logic signed [7:0]  sb;
      logic signed [15:0] sh;
      logic signed [31:0] r;
      s  = w >> (8 * lane);
      sb = s[7:0];
      sh = s[15:0];
      case (f3)
         3'b000:  r = sb;
         3'b001:  r = sh;
         3'b100:  r = {24'h0, s[7:0]};
         3'b101:  r = {16'h0, s[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
      return d;
   endfunction

   function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] lane);
      logic [3:0] one;
      one = 4'b0001;
      if (f3[1:0] == 2'b00) return one << lane;
      if (f3[1:0] == 2'b01) return (one << lane) | (one << (lane + 2'd1));
      return 4'b1111;
   endfunction

   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rw, input int waits);
      req_t e;
      e.we    = wr;
      e.addr  = {a[31:2], 2'b00};
      e.wdata = exp_wdata(f3, sd);
      e.wstrb = wr ? exp_strb(f3, a[1:0]) : 4'b0000;
      req_q.push_back(e);
      if (rd) ld_q.push_back(exp_load(f3, a[1:0], rw));
      mem_read_in = rd; mem_write_in = wr; funct3_in = f3; addr_in = a;
      store_data_in = sd; dmem_ready = 1'b0; dmem_rdata = 32'h0;
      #1;
      chk("idle_stall", 32'(stall_out), 32'd1);
      chk("idle_misaligned", 32'(misaligned_out), 32'd0);
      chk("idle_req", 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      e = req_q.pop_front();
      chk("busy_req", 32'(dmem_req), 32'd1);
      chk("busy_we", 32'(dmem_we), 32'(e.we));
      chk("busy_addr", dmem_addr, e.addr);
      chk("busy_wstrb", 32'(dmem_wstrb), 32'(e.wstrb));
      if (wr) chk("busy_wdata", dmem_wdata, e.wdata);
      for (int i = 0; i < waits; i++) begin
         chk("wait_stall", 32'(stall_out), 32'd1);
         @(posedge clk); #1;
         chk("hold_req", 32'(dmem_req), 32'd1);
         chk("hold_addr", dmem_addr, e.addr);
         chk("hold_wstrb", 32'(dmem_wstrb), 32'(e.wstrb));
         if (wr) chk("hold_wdata", dmem_wdata, e.wdata);
      end
      chk("busy_stall", 32'(stall_out), 32'd1);
      dmem_ready = 1'b1; dmem_rdata = rw;
      @(posedge clk); #1;
      dmem_ready = 1'b0; dmem_rdata = 32'h0;
      chk("done_req", 32'(dmem_req), 32'd0);
      chk("done_we", 32'(dmem_we), 32'd0);
      chk("done_wstrb", 32'(dmem_wstrb), 32'd0);
      chk("done_stall", 32'(stall_out), 32'd0);
      if (rd) last_ld = ld_q.pop_front();
      chk("load_data", load_data_out, last_ld);
      @(posedge clk); #1;
      mem_read_in = 1'b0; mem_write_in = 1'b0;
   endtask

   task automatic do_misaligned(input logic rd, input logic [2:0] f3, input logic [31:0] a);
      mem_read_in = rd; mem_write_in = !rd; funct3_in = f3; addr_in = a;
      store_data_in = 32'h1234_5678;
      #1;
      chk("mis_flag", 32'(misaligned_out), 32'd1);
      chk("mis_stall", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      chk("mis_req", 32'(dmem_req), 32'd0);
      chk("mis_load_held", load_data_out, last_ld);
      mem_read_in = 1'b0; mem_write_in = 1'b0;
      #1;
      chk("mis_flag_clear", 32'(misaligned_out), 32'd0);
   endtask

   initial begin
      logic [2:0] ld_f3[5];
      logic [2:0] f3;
      logic [31:0] a;
      logic        rd;
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      reset = 1'b1; mem_read_in = 1'b0; mem_write_in = 1'b0; funct3_in = 3'b000;
      addr_in = 32'h0; store_data_in = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
      last_ld = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_addr", dmem_addr, 32'h0);
      chk("rst_wdata", dmem_wdata, 32'h0);
      chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
      chk("rst_load", load_data_out, 32'h0);
      chk("rst_stall", 32'(stall_out), 32'd0);

      do_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
      do_access(1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0);
      do_access(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 2);
      chk("plan_lb", load_data_out, 32'hFFFFFF80);
      do_access(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h0080FF00, 2);
      chk("plan_lbu", load_data_out, 32'h00000080);
      do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80011234, 0);
      chk("plan_lh", load_data_out, 32'hFFFF8001);
      do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80011234, 1);
      chk("plan_lhu", load_data_out, 32'h00008001);
      do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h80011234, 0);
      chk("plan_lw", load_data_out, 32'h80011234);
      do_access(1'b0, 1'b1, 3'b001, 32'h0206, 32'hCAFE_7E57, 32'h0, 1);

      do_misaligned(1'b1, 3'b010, 32'h102);
      do_misaligned(1'b1, 3'b001, 32'h101);
      do_misaligned(1'b0, 3'b010, 32'h203);

      addr_in = 32'h0000_0104; funct3_in = 3'b010;
      #1;
      chk("nomem_stall", 32'(stall_out), 32'd0);
      @(posedge clk); #1;
      chk("nomem_req", 32'(dmem_req), 32'd0);
      chk("nomem_load_held", load_data_out, last_ld);

      for (int n = 0; n < 20; n++) begin
         rd = 1'($urandom_range(0, 1));
         f3 = rd ? ld_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         a  = $urandom;
         if (f3[1:0] == 2'b01) a[0] = 1'b0;
         if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
         do_access(rd, !rd, f3, a, $urandom, $urandom, int'($urandom_range(0, 2)));
      end

      do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h5A5A_0001, 0);
      mem_read_in = 1'b1; mem_write_in = 1'b0; funct3_in = 3'b010; addr_in = 32'h200;
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      chk("rstb_req", 32'(dmem_req), 32'd1);
      @(posedge clk); #1;
      chk("rstb_req_hold", 32'(dmem_req), 32'd1);
      reset = 1'b1; mem_read_in = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      last_ld = 32'h0;
      chk("rstb_req_drop", 32'(dmem_req), 32'd0);
      chk("rstb_load", load_data_out, 32'h0);
      chk("rstb_stall", 32'(stall_out), 32'd0);
      chk("rstb_wstrb", 32'(dmem_wstrb), 32'd0);
      do_access(1'b0, 1'b1, 3'b000, 32'h301, 32'h0000_0042, 32'h0, 0);

      chk("queues_empty", 32'(req_q.size() + ld_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
